// File: rtl/slab_interval_reduce_pkg.sv
// Shared constants for the slab interval reducer: FloPoCo (wE=11, wF=21) field
// positions, exception codes, FSM encodings and real-value ordering helpers.
package slab_interval_reduce_pkg;

    localparam int WIDTH = 34;
    localparam int WE    = 11;
    localparam int WF    = 21;
    localparam int AXES  = 3;
    localparam int CNT_W = $clog2(AXES);

    localparam int EXC_HI  = 34;
    localparam int EXC_LO  = 33;
    localparam int SIGN    = 32;
    localparam int EXP_HI  = 31;
    localparam int EXP_LO  = 21;
    localparam int FRAC_HI = 20;

    localparam logic [1:0] EXC_ZERO = 2'b00;
    localparam logic [1:0] EXC_NORM = 2'b01;
    localparam logic [1:0] EXC_INF  = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    // Coarse ordering class: -inf < negative normal < zero < positive normal < +inf.
    localparam logic [2:0] RANK_NINF = 3'd0;
    localparam logic [2:0] RANK_NEG  = 3'd1;
    localparam logic [2:0] RANK_ZERO = 3'd2;
    localparam logic [2:0] RANK_POS  = 3'd3;
    localparam logic [2:0] RANK_PINF = 3'd4;

    function automatic logic [2:0] fp_rank(input logic [WIDTH:0] x);
        logic [2:0] r;
        case (x[EXC_HI:EXC_LO])
            EXC_NORM: r = x[SIGN] ? RANK_NEG : RANK_POS;
            EXC_INF:  r = x[SIGN] ? RANK_NINF : RANK_PINF;
            default:  r = RANK_ZERO;
        endcase
        return r;
    endfunction

    function automatic logic fp_is_nan(input logic [WIDTH:0] x);
        return x[EXC_HI:EXC_LO] == EXC_NAN;
    endfunction

    // Strictly below zero; signed zeros are not negative.
    function automatic logic fp_is_neg(input logic [WIDTH:0] x);
        return x[SIGN] && (x[EXC_HI:EXC_LO] == EXC_NORM || x[EXC_HI:EXC_LO] == EXC_INF);
    endfunction

endpackage

// File: rtl/slab_interval_reduce_if.sv
// Bus between the per-axis slab producer, the reducer and the result consumer.
interface slab_interval_reduce_if;
    import slab_interval_reduce_pkg::*;

    // Both channels use strict valid/ready: a beat transfers on a cycle where
    // valid && ready; once raised, valid and its payload stay stable until then.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   t_near;
    logic [WIDTH:0]   t_far;
    logic             out_valid;
    logic             out_ready;
    logic             hit;
    logic [WIDTH:0]   t_enter;
    logic [WIDTH:0]   t_exit;
    logic [0:0]       dbg_state;

    modport master (
        output in_valid, t_near, t_far, out_ready,
        input  in_ready, out_valid, hit, t_enter, t_exit, dbg_state
    );

    modport slave (
        input  in_valid, t_near, t_far, out_ready,
        output in_ready, out_valid, hit, t_enter, t_exit, dbg_state
    );

endinterface

// File: rtl/slab_interval_reduce_fp_order_cmp.sv
// Combinational real-value comparison of two FloPoCo words; NaN on either side
// makes the pair unordered and clears both lt and eq.
module slab_interval_reduce_fp_order_cmp
    import slab_interval_reduce_pkg::*;
(
    input  logic [WIDTH:0] a_i,
    input  logic [WIDTH:0] b_i,
    output logic           a_lt_b_o,
    output logic           a_eq_b_o,
    output logic           unordered_o
);

    logic [2:0] rank_a;
    logic [2:0] rank_b;
    logic       mag_lt;
    logic       mag_eq;

    assign rank_a      = fp_rank(a_i);
    assign rank_b      = fp_rank(b_i);
    assign mag_lt      = a_i[EXP_HI:0] < b_i[EXP_HI:0];
    assign mag_eq      = a_i[EXP_HI:0] == b_i[EXP_HI:0];
    assign unordered_o = fp_is_nan(a_i) || fp_is_nan(b_i);

    always_comb begin
        a_lt_b_o = 1'b0;
        a_eq_b_o = 1'b0;
        if (!unordered_o) begin
            if (rank_a != rank_b) begin
                a_lt_b_o = rank_a < rank_b;
            end else if (rank_a == RANK_NEG) begin
                // Larger magnitude is the smaller negative value.
                a_lt_b_o = !mag_lt && !mag_eq;
                a_eq_b_o = mag_eq;
            end else if (rank_a == RANK_POS) begin
                a_lt_b_o = mag_lt;
                a_eq_b_o = mag_eq;
            end else begin
                a_eq_b_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slab_interval_reduce.sv
// Reduces per-axis (t_near, t_far) pairs to max(t_near)/min(t_far) over AXES
// beats, then presents a registered hit flag with the reduced interval.
module slab_interval_reduce
    import slab_interval_reduce_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    slab_interval_reduce_if.slave bus
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH:0]   acc_near_q, acc_near_d;
    logic [WIDTH:0]   acc_far_q, acc_far_d;
    logic             nan_q, nan_d;
    logic             hit_q, hit_d;

    logic accept;
    logic final_axis;
    logic nan_in;
    logic near_lt, near_eq_unused, near_unord;
    logic far_lt, far_eq_unused, far_unord;
    logic hit_lt, hit_eq, hit_unord_unused;

    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.hit       = hit_q;
    assign bus.t_enter   = acc_near_q;
    assign bus.t_exit    = acc_far_q;
    assign bus.dbg_state = state_q;

    assign accept     = bus.in_valid && bus.in_ready;
    assign final_axis = (count_q == CNT_W'(AXES - 1));
    assign nan_in     = fp_is_nan(bus.t_near) || fp_is_nan(bus.t_far);

    slab_interval_reduce_fp_order_cmp u_cmp_near (
        .a_i(acc_near_q), .b_i(bus.t_near),
        .a_lt_b_o(near_lt), .a_eq_b_o(near_eq_unused), .unordered_o(near_unord)
    );

    slab_interval_reduce_fp_order_cmp u_cmp_far (
        .a_i(bus.t_far), .b_i(acc_far_q),
        .a_lt_b_o(far_lt), .a_eq_b_o(far_eq_unused), .unordered_o(far_unord)
    );

    slab_interval_reduce_fp_order_cmp u_cmp_hit (
        .a_i(acc_near_d), .b_i(acc_far_d),
        .a_lt_b_o(hit_lt), .a_eq_b_o(hit_eq), .unordered_o(hit_unord_unused)
    );

    // Strict compares only, so ties keep the accumulator; NaN never replaces it.
    always_comb begin
        acc_near_d = acc_near_q;
        acc_far_d  = acc_far_q;
        nan_d      = nan_q;
        if (accept) begin
            if (count_q == '0) begin
                acc_near_d = bus.t_near;
                acc_far_d  = bus.t_far;
                nan_d      = nan_in;
            end else begin
                if (near_lt && !near_unord) acc_near_d = bus.t_near;
                if (far_lt && !far_unord)   acc_far_d  = bus.t_far;
                nan_d = nan_q || nan_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hit_d   = hit_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (final_axis) begin
                        state_d = ST_DONE;
                        count_d = '0;
                        hit_d   = !nan_d && (hit_lt || hit_eq) && !fp_is_neg(acc_far_d);
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: begin
                if (bus.out_ready) begin
                    state_d = ST_ACCUM;
                    count_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ACCUM;
            count_q    <= '0;
            acc_near_q <= '0;
            acc_far_q  <= '0;
            nan_q      <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_near_q <= acc_near_d;
            acc_far_q  <= acc_far_d;
            nan_q      <= nan_d;
            hit_q      <= hit_d;
        end
    end

endmodule

// File: tb/tb_slab_interval_reduce.sv
// Directed bench for slab_interval_reduce: table of three-axis rays with
// hand-computed intervals, plus back-pressure and mid-ray reset sequences.
module tb_slab_interval_reduce;

    localparam logic [34:0] P0   = {2'b00, 1'b0, 11'd0,    21'd0};
    localparam logic [34:0] N0   = {2'b00, 1'b1, 11'd0,    21'd0};
    localparam logic [34:0] HALF = {2'b01, 1'b0, 11'd1022, 21'd0};
    localparam logic [34:0] ONE  = {2'b01, 1'b0, 11'd1023, 21'd0};
    localparam logic [34:0] TWO  = {2'b01, 1'b0, 11'd1024, 21'd0};
    localparam logic [34:0] THR  = {2'b01, 1'b0, 11'd1024, 21'h100000};
    localparam logic [34:0] FOUR = {2'b01, 1'b0, 11'd1025, 21'd0};
    localparam logic [34:0] FIVE = {2'b01, 1'b0, 11'd1025, 21'h080000};
    localparam logic [34:0] M1   = {2'b01, 1'b1, 11'd1023, 21'd0};
    localparam logic [34:0] M2   = {2'b01, 1'b1, 11'd1024, 21'd0};
    localparam logic [34:0] M3   = {2'b01, 1'b1, 11'd1024, 21'h100000};
    localparam logic [34:0] PINF = {2'b10, 1'b0, 11'd0,    21'd0};
    localparam logic [34:0] NINF = {2'b10, 1'b1, 11'd0,    21'd0};
    localparam logic [34:0] QNAN = {2'b11, 1'b0, 11'd0,    21'd0};
    localparam int NVEC = 8;

    typedef struct {
        string            name;
        logic [2:0][34:0] near;
        logic [2:0][34:0] far;
        logic             exp_hit;
        logic [34:0]      exp_enter;
        logic [34:0]      exp_exit;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[NVEC];

    slab_interval_reduce_if bus ();

    slab_interval_reduce dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drives one ray with out_ready low; returns on the negedge after the final accept.
    task automatic run_ray(input logic [2:0][34:0] n, input logic [2:0][34:0] f, input string tag);
        for (int a = 0; a < 3; a++) begin
            @(negedge clk);
            if (a > 0) chk({tag, "/early_valid"}, 64'(bus.out_valid), 64'd0);
            bus.in_valid = 1'b1;
            bus.t_near   = n[a];
            bus.t_far    = f[a];
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "/latency"}, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic check_result(input vec_t v);
        chk({v.name, "/hit"},     64'(bus.hit),     64'(v.exp_hit));
        chk({v.name, "/t_enter"}, 64'(bus.t_enter), 64'(v.exp_enter));
        chk({v.name, "/t_exit"},  64'(bus.t_exit),  64'(v.exp_exit));
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "/valid_clear"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "/ready_back"},  64'(bus.in_ready),  64'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.t_near    = '0;
        bus.t_far     = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{"overlap",   '{HALF, TWO, ONE},  '{FIVE, THR, FOUR}, 1'b1, TWO, THR};
        vecs[1] = '{"disjoint",  '{P0, THR, ONE},    '{FIVE, FOUR, TWO}, 1'b0, THR, TWO};
        vecs[2] = '{"behind",    '{M3, M3, M3},      '{M1, M1, M1},      1'b0, M3,  M1};
        vecs[3] = '{"neg_zero",  '{M3, M3, M3},      '{N0, N0, N0},      1'b1, M3,  N0};
        vecs[4] = '{"nan_near",  '{TWO, QNAN, ONE},  '{FIVE, THR, FOUR}, 1'b0, TWO, THR};
        vecs[5] = '{"inf_axis",  '{TWO, ONE, NINF},  '{THR, FOUR, PINF}, 1'b1, TWO, THR};
        vecs[6] = '{"grazing",   '{P0, TWO, ONE},    '{FIVE, THR, TWO},  1'b1, TWO, TWO};
        vecs[7] = '{"neg_max",   '{M2, M1, M3},      '{THR, TWO, ONE},   1'b1, M1,  ONE};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset/out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset/in_ready",  64'(bus.in_ready),  64'd1);
        chk("reset/hit",       64'(bus.hit),       64'd0);
        chk("reset/t_enter",   64'(bus.t_enter),   64'd0);
        chk("reset/t_exit",    64'(bus.t_exit),    64'd0);
        chk("reset/state",     64'(bus.dbg_state), 64'd0);

        // Table is listed axis 2 first (packed [2:0]), so index 0 is axis x.
        for (int i = 0; i < NVEC; i++) begin
            run_ray(vecs[i].near, vecs[i].far, vecs[i].name);
            check_result(vecs[i]);
            release_result(vecs[i].name);
        end

        // Back-pressure: result must hold and stray input beats must be dropped.
        run_ray(vecs[0].near, vecs[0].far, "stall");
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (c % 2) == 0;
            bus.t_near   = QNAN;
            bus.t_far    = M3;
            @(negedge clk);
            chk("stall/out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall/in_ready",  64'(bus.in_ready),  64'd0);
            chk("stall/t_enter",   64'(bus.t_enter),   64'(TWO));
            chk("stall/t_exit",    64'(bus.t_exit),    64'(THR));
            chk("stall/hit",       64'(bus.hit),       64'd1);
        end
        bus.in_valid = 1'b0;
        release_result("stall");
        run_ray(vecs[1].near, vecs[1].far, "after_stall");
        check_result(vecs[1]);
        release_result("after_stall");

        // Mid-ray reset: two accepted axes are discarded.
        for (int a = 0; a < 2; a++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.t_near   = (a == 0) ? QNAN : FIVE;
            bus.t_far    = M3;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst/out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst/in_ready",  64'(bus.in_ready),  64'd1);
        chk("midrst/t_enter",   64'(bus.t_enter),   64'd0);
        chk("midrst/t_exit",    64'(bus.t_exit),    64'd0);
        run_ray(vecs[0].near, vecs[0].far, "fresh");
        check_result(vecs[0]);
        release_result("fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
